sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_pkg.sv | 12 +
 rtl/sram_port_arbiter_owner_fifo.sv | 59 +++++
 rtl/sram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: owner encoding and default depth.
// The ARB_RR_EN macro selects round-robin arbitration in sram_port_arbiter.
package sram_port_arbiter_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int DEPTH_DEFAULT = 4;

endpackage

// File: rtl/sram_port_arbiter_owner_fifo.sv
// In-order FIFO of granted owner IDs; head identifies who receives the next response.
// DEPTH must be a power of two so the pointers wrap naturally.
module owner_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  owner_e                 din,
    output owner_e                 dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    owner_e              mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [$clog2(DEPTH):0] count_q;
    logic                do_push_s;
    logic                do_pop_s;

    assign full      = (count_q == DEPTH[$clog2(DEPTH):0]);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer, count and storage update; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (do_push_s && !do_pop_s) begin
                count_q <= count_q + {{PW{1'b0}}, 1'b1};
            end else if (do_pop_s && !do_push_s) begin
                count_q <= count_q - {{PW{1'b0}}, 1'b1};
            end else begin
                count_q <= count_q;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates instruction and data SRAM-like ports onto one shared port.
// Define ARB_RR_EN for round-robin contention handling; default is data-first.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        down_req,
    output logic        down_wr,
    output logic [1:0]  down_size,
    output logic [3:0]  down_wstrb,
    output logic [31:0] down_addr,
    output logic [31:0] down_wdata,
    input  logic        down_addr_ok,
    input  logic        down_data_ok,
    input  logic [31:0] down_rdata,
    output logic        arb_err
);

    logic                   lock_q, lock_d;
    owner_e                 lock_owner_q, lock_owner_d;
    logic                   arb_err_q, arb_err_d;
    owner_e                 pick_s;
    owner_e                 owner_s;
    logic                   grant_s;
    logic                   accept_s;
    logic                   pop_s;
    owner_e                 fifo_dout_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
`ifdef ARB_RR_EN
    owner_e                 last_grant_q, last_grant_d;
`endif

    // Priority policy between two simultaneous requesters.
    always_comb begin
        pick_s = OWN_INST;
`ifdef ARB_RR_EN
        if (inst_req && data_req) begin
            pick_s = (last_grant_q == OWN_DATA) ? OWN_INST : OWN_DATA;
        end else if (data_req) begin
            pick_s = OWN_DATA;
        end else begin
            pick_s = OWN_INST;
        end
`else
        if (data_req) begin
            pick_s = OWN_DATA;
        end else begin
            pick_s = OWN_INST;
        end
`endif
    end

    // Grant selection and shared request mux; a held lock pins the owner.
    always_comb begin
        owner_s    = OWN_INST;
        grant_s    = 1'b0;
        if (reset) begin
            grant_s = 1'b0;
        end else if (lock_q) begin
            owner_s = lock_owner_q;
            grant_s = 1'b1;
        end else if (!fifo_full_s && (inst_req || data_req)) begin
            owner_s = pick_s;
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        down_req   = 1'b0;
        down_wr    = 1'b0;
        down_size  = 2'b00;
        down_wstrb = 4'h0;
        down_addr  = 32'h0000_0000;
        down_wdata = 32'h0000_0000;
        if (owner_s == OWN_DATA) begin
            down_req   = grant_s & data_req;
            down_wr    = data_wr;
            down_size  = data_size;
            down_wstrb = data_wstrb;
            down_addr  = data_addr;
            down_wdata = data_wdata;
        end else begin
            down_req   = grant_s & inst_req;
            down_size  = inst_size;
            down_addr  = inst_addr;
        end
    end

    assign accept_s     = down_req & down_addr_ok;
    assign inst_addr_ok = accept_s & (owner_s == OWN_INST);
    assign data_addr_ok = accept_s & (owner_s == OWN_DATA);
    assign pop_s        = ~reset & down_data_ok & ~fifo_empty_s;
    assign inst_data_ok = pop_s & (fifo_dout_s == OWN_INST);
    assign data_data_ok = pop_s & (fifo_dout_s == OWN_DATA);
    assign inst_rdata   = down_rdata;
    assign data_rdata   = down_rdata;
    assign arb_err      = arb_err_q;

    // Next-state for lock, round-robin history and the sticky error flag.
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (down_req && !down_addr_ok) begin
            lock_d       = 1'b1;
            lock_owner_d = owner_s;
        end else if (down_addr_ok) begin
            lock_d       = 1'b0;
        end else begin
            lock_d       = lock_q;
        end
        arb_err_d = arb_err_q | (down_data_ok & fifo_empty_s);
`ifdef ARB_RR_EN
        if (accept_s) begin
            last_grant_d = owner_s;
        end else begin
            last_grant_d = last_grant_q;
        end
`endif
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_INST;
            arb_err_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q <= OWN_INST;
`endif
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            arb_err_q    <= arb_err_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept_s),
        .pop   (pop_s),
        .din   (owner_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an owner/response scoreboard queue.
// Build with +define+ARB_RR_EN to exercise the round-robin contention case.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        down_req, down_wr;
    logic [1:0]  down_size;
    logic [3:0]  down_wstrb;
    logic [31:0] down_addr, down_wdata;
    logic        down_addr_ok, down_data_ok;
    logic [31:0] down_rdata;
    logic        arb_err;

    int     n_cmp = 0;
    int     n_err = 0;
    owner_e exp_q[$];

    always #5 clk = ~clk;

    sram_port_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .down_req(down_req), .down_wr(down_wr), .down_size(down_size),
        .down_wstrb(down_wstrb), .down_addr(down_addr), .down_wdata(down_wdata),
        .down_addr_ok(down_addr_ok), .down_data_ok(down_data_ok), .down_rdata(down_rdata),
        .arb_err(arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next cycle: inputs change just after the falling edge; response strobe defaults low.
    task automatic next();
        @(negedge clk);
        down_data_ok = 1'b0;
    endtask

    // Return one response and check it is routed to the oldest expected owner.
    task automatic ret(input string tag, input logic [31:0] rd);
        owner_e o;
        next();
        down_data_ok = 1'b1;
        down_rdata   = rd;
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            o = exp_q.pop_front();
            chk({tag, "_iok"}, {31'd0, inst_data_ok}, {31'd0, o == OWN_INST});
            chk({tag, "_dok"}, {31'd0, data_data_ok}, {31'd0, o == OWN_DATA});
            chk({tag, "_rd"}, (o == OWN_INST) ? inst_rdata : data_rdata, rd);
        end
    endtask

    initial begin
        reset = 1'b1; inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        down_addr_ok = 1'b1; down_data_ok = 1'b1; down_rdata = 32'h0;
        @(negedge clk);
        down_data_ok = 1'b1;
        #1;
        chk("rst_down_req", {31'd0, down_req}, 32'd0);
        chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        next();
        reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; down_addr_ok = 1'b0;
        #1;
        chk("rst_arb_err", {31'd0, arb_err}, 32'd0);

        // Single instruction fetch, response two cycles later.
        next();
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; down_addr_ok = 1'b1;
        #1;
        chk("i1_aok", {31'd0, inst_addr_ok}, 32'd1);
        chk("i1_addr", down_addr, 32'h1C00_0000);
        chk("i1_wr", {31'd0, down_wr}, 32'd0);
        exp_q.push_back(OWN_INST);
        next();
        inst_req = 1'b0; down_addr_ok = 1'b0;
        #1;
        chk("i1_idle", {31'd0, down_req}, 32'd0);
        ret("i1_ret", 32'h0280_0C0C);

        // Contention between both ports.
        next();
        inst_req = 1'b1; inst_addr = 32'h1C00_0100;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0200;
        down_addr_ok = 1'b1;
`ifdef ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next();
            #1;
            chk("rr_dok", {31'd0, data_addr_ok}, {31'd0, (k % 2) == 0});
            chk("rr_iok", {31'd0, inst_addr_ok}, {31'd0, (k % 2) == 1});
            exp_q.push_back(((k % 2) == 0) ? OWN_DATA : OWN_INST);
        end
        next();
        inst_req = 1'b0; data_req = 1'b0; down_addr_ok = 1'b0;
        for (int k = 0; k < 4; k++) ret("rr_ret", 32'hA000_0000 + k);
`else
        #1;
        chk("fp_dok", {31'd0, data_addr_ok}, 32'd1);
        chk("fp_iok", {31'd0, inst_addr_ok}, 32'd0);
        chk("fp_addr", down_addr, 32'h8000_0200);
        exp_q.push_back(OWN_DATA);
        next();
        data_req = 1'b0;
        #1;
        chk("fp_iok2", {31'd0, inst_addr_ok}, 32'd1);
        exp_q.push_back(OWN_INST);
        next();
        inst_req = 1'b0; down_addr_ok = 1'b0;
        ret("fp_ret0", 32'h1111_0000);
        ret("fp_ret1", 32'h2222_0000);
`endif

        // Stalled data store holds the grant while inst arrives.
        next();
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
        data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF; down_addr_ok = 1'b0;
        #1;
        chk("lk_req", {31'd0, down_req}, 32'd1);
        chk("lk_dok0", {31'd0, data_addr_ok}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            next();
            inst_req = 1'b1; inst_addr = 32'h1C00_0010;
            #1;
            chk("lk_addr", down_addr, 32'h8000_1000);
            chk("lk_iok", {31'd0, inst_addr_ok}, 32'd0);
        end
        next();
        down_addr_ok = 1'b1;
        #1;
        chk("lk_dok", {31'd0, data_addr_ok}, 32'd1);
        chk("lk_wdata", down_wdata, 32'hDEAD_BEEF);
        exp_q.push_back(OWN_DATA);
        next();
        data_req = 1'b0;
        #1;
        chk("lk_iok2", {31'd0, inst_addr_ok}, 32'd1);
        chk("lk_iaddr", down_addr, 32'h1C00_0010);
        chk("lk_istrb", {28'd0, down_wstrb}, 32'd0);
        exp_q.push_back(OWN_INST);
        next();
        inst_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; down_addr_ok = 1'b0;
        ret("lk_ret0", 32'h3333_0000);
        ret("lk_ret1", 32'h4444_0000);

        // Inst then data issued; responses come back in order.
        next();
        inst_req = 1'b1; inst_addr = 32'h1C00_0020; down_addr_ok = 1'b1;
        #1;
        chk("io_iok", {31'd0, inst_addr_ok}, 32'd1);
        exp_q.push_back(OWN_INST);
        next();
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h8000_0040;
        #1;
        chk("io_dok", {31'd0, data_addr_ok}, 32'd1);
        exp_q.push_back(OWN_DATA);
        next();
        data_req = 1'b0; down_addr_ok = 1'b0;
        ret("io_ret0", 32'h5555_0000);
        ret("io_ret1", 32'h6666_0000);

        // Fill to DEPTH, then block; pop plus pending request refills to full.
        next();
        inst_req = 1'b1; down_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next();
            inst_addr = 32'h1C00_0100 + 32'(k * 4);
            #1;
            chk("fl_iok", {31'd0, inst_addr_ok}, 32'd1);
            exp_q.push_back(OWN_INST);
        end
        next();
        #1;
        chk("fl_block", {31'd0, down_req}, 32'd0);
        ret("fl_ret0", 32'h7777_0000);
        chk("fl_block2", {31'd0, down_req}, 32'd0);
        next();
        #1;
        chk("fl_refill", {31'd0, inst_addr_ok}, 32'd1);
        exp_q.push_back(OWN_INST);
        next();
        #1;
        chk("fl_full", {31'd0, down_req}, 32'd0);
        inst_req = 1'b0; down_addr_ok = 1'b0;
        for (int k = 0; k < 4; k++) ret("fl_drain", 32'h8888_0000 + k);

        // Response with nothing outstanding.
        next();
        #1;
        chk("er_pre", {31'd0, arb_err}, 32'd0);
        next();
        down_data_ok = 1'b1; down_rdata = 32'h9999_0000;
        #1;
        chk("er_nook", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        next();
        #1;
        chk("er_set", {31'd0, arb_err}, 32'd1);
        next();
        next();
        #1;
        chk("er_sticky", {31'd0, arb_err}, 32'd1);
        reset = 1'b1;
        next();
        reset = 1'b0;
        #1;
        chk("er_clr", {31'd0, arb_err}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
